// File: rtl/mem_stage_if.sv
// mem_stage_if: pipeline-side and data-memory-side signals of the MEM stage
interface mem_stage_if;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [31:0] mem_pc;
  logic [5:0]  stall;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_pc;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_sel;
  logic [31:0] dm_wdata;
  logic        stallreq;
  logic        addr_err;
  logic        bus_err;
  modport master (
    output mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2, mem_pc, stall, dm_ack, dm_rdata,
    input  wb_wd, wb_wreg, wb_wdata, wb_pc, dm_req, dm_we, dm_addr, dm_sel, dm_wdata, stallreq, addr_err, bus_err
  );
  modport slave (
    input  mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2, mem_pc, stall, dm_ack, dm_rdata,
    output wb_wd, wb_wreg, wb_wdata, wb_pc, dm_req, dm_we, dm_addr, dm_sel, dm_wdata, stallreq, addr_err, bus_err
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with data-memory handshake, load extension and access timeout
module mem_stage (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [7:0]  op_q;
  logic [1:0]  lo_q;
  logic        we_q, wreg_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  sel_q;
  logic [4:0]  wd_q;
  logic        is_ld, is_st, is_b, is_h, mis;
  logic [3:0]  sel;
  logic [31:0] st_data, sh, ld_data;
  logic        unused;
  assign unused = ^{bus.stall[5], bus.stall[3:0]};
  // decode the incoming op and extract the addressed lanes of the returned word
  always_comb begin
    is_ld   = bus.mem_aluop inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    is_st   = bus.mem_aluop inside {OP_SB, OP_SH, OP_SW};
    is_b    = bus.mem_aluop inside {OP_LB, OP_LBU, OP_SB};
    is_h    = bus.mem_aluop inside {OP_LH, OP_LHU, OP_SH};
    mis     = (is_ld | is_st) & (is_h ? bus.mem_mem_addr[0] : !is_b & |bus.mem_mem_addr[1:0]);
    sel     = is_b ? 4'b0001 << bus.mem_mem_addr[1:0] : is_h ? (bus.mem_mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_data = is_b ? {4{bus.mem_reg2[7:0]}} : is_h ? {2{bus.mem_reg2[15:0]}} : bus.mem_reg2;
    sh      = bus.dm_rdata >> {lo_q, 3'b000};
    ld_data = op_q == OP_LB  ? {{24{sh[7]}}, sh[7:0]} :
              op_q == OP_LBU ? {24'b0, sh[7:0]} :
              op_q == OP_LH  ? {{16{sh[15]}}, sh[15:0]} :
              op_q == OP_LHU ? {16'b0, sh[15:0]} : bus.dm_rdata;
  end
  // next state and outputs; IDLE drives the bus from inputs, WAIT/DONE from the captured request
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    err_d        = err_q;
    bus.wb_wd    = bus.mem_wd;
    bus.wb_wreg  = bus.mem_wreg;
    bus.wb_wdata = bus.mem_wdata;
    bus.wb_pc    = bus.mem_pc;
    bus.dm_req   = 1'b0;
    bus.dm_we    = is_st;
    bus.dm_addr  = {bus.mem_mem_addr[31:2], 2'b00};
    bus.dm_sel   = sel;
    bus.dm_wdata = st_data;
    bus.stallreq = 1'b0;
    bus.addr_err = 1'b0;
    bus.bus_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_st | mis) bus.wb_wreg = 1'b0;
        if (mis) bus.addr_err = 1'b1;
        if ((is_ld | is_st) & !mis) begin
          bus.dm_req   = 1'b1;
          bus.stallreq = 1'b1;
          cnt_d        = 8'd0;
          err_d        = 1'b0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        bus.dm_req   = 1'b1;
        bus.stallreq = 1'b1;
        bus.dm_we    = we_q;
        bus.dm_addr  = addr_q;
        bus.dm_sel   = sel_q;
        bus.dm_wdata = wdata_q;
        bus.wb_wd    = wd_q;
        bus.wb_wreg  = wreg_q;
        bus.wb_wdata = data_q;
        if (bus.dm_ack) begin
          data_d  = ld_data;
          state_d = S_DONE;
        end else if (cnt_q == 8'hFF) begin
          bus.bus_err = 1'b1;
          err_d       = 1'b1;
          state_d     = S_DONE;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_DONE: begin
        bus.dm_we    = we_q;
        bus.dm_addr  = addr_q;
        bus.dm_sel   = sel_q;
        bus.dm_wdata = wdata_q;
        bus.wb_wd    = wd_q;
        bus.wb_wreg  = wreg_q & ~err_q;
        bus.wb_wdata = data_q;
        if (!bus.stall[4]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // FSM, timeout counter and load result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  // capture the request while idle so the bus stays stable for the whole access
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      op_q    <= bus.mem_aluop;
      lo_q    <= bus.mem_mem_addr[1:0];
      we_q    <= is_st;
      wreg_q  <= bus.mem_wreg & is_ld;
      addr_q  <= {bus.mem_mem_addr[31:2], 2'b00};
      sel_q   <= sel;
      wdata_q <= st_data;
      wd_q    <= bus.mem_wd;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transaction-level check of mem_stage against a behavioural model
module tb_mem_stage;
  localparam logic [7:0] ADD = 8'h20, ORR = 8'h25;
  localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;
  localparam int TMO = 256;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0, n_err = 0;
  logic chk_on = 1'b0;
  logic        e_req, e_stall, e_aerr, e_berr, e_we, e_wreg, ck_wd, ck_wreg, ck_wdata, ck_dwd;
  logic [31:0] e_pc, e_addr, e_dwd, e_wdata;
  logic [3:0]  e_sel;
  logic [4:0]  e_wd;
  logic        obs_req0, obs_aerr0, obs_wreg0, obs_stall0, obs_we0, obs_done_wreg;
  logic [31:0] obs_wdata0, obs_addr0, obs_dwd0, obs_done_wdata;
  logic [3:0]  obs_sel0;
  int          obs_stall, obs_berr, obs_done, obs_chg;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // compare DUT outputs against the model's expectation for the current cycle
  always @(negedge clk) if (chk_on) begin
    check("wb_pc", bus.wb_pc, e_pc);
    check("dm_req", 32'(bus.dm_req), 32'(e_req));
    check("stallreq", 32'(bus.stallreq), 32'(e_stall));
    check("addr_err", 32'(bus.addr_err), 32'(e_aerr));
    check("bus_err", 32'(bus.bus_err), 32'(e_berr));
    if (ck_wd) check("wb_wd", 32'(bus.wb_wd), 32'(e_wd));
    if (ck_wreg) check("wb_wreg", 32'(bus.wb_wreg), 32'(e_wreg));
    if (ck_wdata) check("wb_wdata", bus.wb_wdata, e_wdata);
    if (e_req) begin
      check("dm_we", 32'(bus.dm_we), 32'(e_we));
      check("dm_addr", bus.dm_addr, e_addr);
      check("dm_sel", 32'(bus.dm_sel), 32'(e_sel));
      if (ck_dwd) check("dm_wdata", bus.dm_wdata, e_dwd);
    end
  end

  function automatic int sz(input logic [7:0] op);
    return (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : (op == LW || op == SW) ? 4 : 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [7:0] op, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * a);
    if (op == LB) return s[7] ? (s & 32'hFF) | 32'hFFFFFF00 : s & 32'hFF;
    if (op == LBU) return s & 32'hFF;
    if (op == LH) return s[15] ? (s & 32'hFFFF) | 32'hFFFF0000 : s & 32'hFFFF;
    if (op == LHU) return s & 32'hFFFF;
    return rd;
  endfunction

  // one instruction through the stage: IDLE cycle, WAIT cycles until ack or timeout, DONE cycles
  task automatic txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                     input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                     input int ack_at, input int hold, input int abort_at,
                     input logic fix, input logic [31:0] rd_fix);
    logic ld, st, mis, to;
    logic [1:0] a;
    logic [31:0] rd, got, prev;
    int last;
    ld = op inside {LB, LBU, LH, LHU, LW};
    st = op inside {SB, SH, SW};
    a = addr[1:0];
    mis = (sz(op) == 2 && a[0]) || (sz(op) == 4 && a != 2'b00);
    bus.mem_aluop = op; bus.mem_mem_addr = addr; bus.mem_reg2 = reg2; bus.mem_wdata = wdata;
    bus.mem_wd = wd; bus.mem_wreg = wreg; bus.mem_pc = $urandom;
    e_pc = bus.mem_pc;
    obs_stall = 0; obs_berr = 0; obs_done = 0; obs_chg = 0; got = 32'd0;
    chk_on = 1'b1;
    if (!(ld || st) || mis) begin
      bus.dm_ack = 1'($urandom_range(0, 1)); bus.dm_rdata = $urandom; bus.stall = 6'($urandom);
      e_req = 1'b0; e_stall = 1'b0; e_aerr = mis; e_berr = 1'b0;
      ck_wd = !mis; e_wd = wd; ck_wreg = 1'b1; e_wreg = (ld || st) ? 1'b0 : wreg;
      ck_wdata = !(ld || st); e_wdata = wdata; ck_dwd = 1'b0;
      #4;
      obs_req0 = bus.dm_req; obs_aerr0 = bus.addr_err; obs_wreg0 = bus.wb_wreg;
      obs_stall0 = bus.stallreq; obs_wdata0 = bus.wb_wdata;
      @(posedge clk); #1;
      return;
    end
    to = ack_at > TMO;
    last = to ? TMO : ack_at;
    for (int c = 0; c <= last; c++) begin
      if (abort_at > 0 && c == abort_at) return;
      rd = fix ? rd_fix : $urandom;
      bus.dm_rdata = rd;
      bus.dm_ack = (c == ack_at) || (c == 0 && $urandom_range(0, 1) == 1);
      bus.stall = 6'($urandom);
      e_req = 1'b1; e_stall = 1'b1; e_aerr = 1'b0; e_berr = to && c == last;
      e_we = st; e_addr = {addr[31:2], 2'b00};
      e_sel = sz(op) == 1 ? 4'(1 << a) : sz(op) == 2 ? (a >= 2 ? 4'b1100 : 4'b0011) : 4'b1111;
      ck_dwd = st; e_dwd = sz(op) == 1 ? {4{reg2[7:0]}} : sz(op) == 2 ? {2{reg2[15:0]}} : reg2;
      ck_wd = 1'b0; ck_wdata = 1'b0; ck_wreg = st; e_wreg = 1'b0;
      if (c == last && !to) got = load_val(op, a, rd);
      #4;
      obs_stall += int'(bus.stallreq); obs_berr += int'(bus.bus_err);
      if (c == 0) begin
        obs_req0 = bus.dm_req; obs_sel0 = bus.dm_sel; obs_addr0 = bus.dm_addr;
        obs_we0 = bus.dm_we; obs_dwd0 = bus.dm_wdata;
      end
      @(posedge clk); #1;
    end
    prev = 32'd0;
    for (int c = 0; c <= hold; c++) begin
      bus.stall = 6'($urandom); bus.stall[4] = c < hold;
      bus.dm_ack = 1'($urandom_range(0, 1)); bus.dm_rdata = $urandom;
      e_req = 1'b0; e_stall = 1'b0; e_aerr = 1'b0; e_berr = 1'b0;
      ck_wd = 1'b1; e_wd = wd; ck_wreg = 1'b1; e_wreg = ld && wreg && !to;
      ck_wdata = ld && !to; e_wdata = got; ck_dwd = 1'b0;
      #4;
      obs_done++;
      if (c == 0) obs_done_wdata = bus.wb_wdata;
      else if (bus.wb_wdata !== prev) obs_chg++;
      prev = bus.wb_wdata; obs_done_wreg = bus.wb_wreg;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] ops [10];
    int r, ack;
    ops = '{ADD, ORR, LB, LBU, LH, LHU, LW, SB, SH, SW};
    bus.mem_aluop = ADD; bus.mem_mem_addr = 0; bus.mem_reg2 = 0; bus.mem_wdata = 0;
    bus.mem_wd = 0; bus.mem_wreg = 0; bus.mem_pc = 0; bus.stall = 0; bus.dm_ack = 0; bus.dm_rdata = 0;
    {e_req, e_stall, e_aerr, e_berr, e_we, e_wreg, ck_wd, ck_wreg, ck_wdata, ck_dwd} = '0;
    e_pc = 0; e_addr = 0; e_dwd = 0; e_wdata = 0; e_sel = 0; e_wd = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset dm_req", 32'(bus.dm_req), 32'd0);
    check("reset stallreq", 32'(bus.stallreq), 32'd0);
    check("reset addr_err", 32'(bus.addr_err), 32'd0);
    check("reset bus_err", 32'(bus.bus_err), 32'd0);
    rst = 1'b0;
    txn(ADD, 32'h0, 32'h0, 32'h1234, 5'd3, 1'b1, 0, 0, 0, 1'b0, 32'h0);
    check("add wb_wdata", obs_wdata0, 32'h1234);
    check("add wb_wreg", 32'(obs_wreg0), 32'd1);
    check("add stallreq", 32'(obs_stall0), 32'd0);
    txn(LB, 32'h103, 32'h0, 32'h0, 5'd4, 1'b1, 3, 0, 0, 1'b1, 32'h805A3C11);
    check("lb dm_sel", 32'(obs_sel0), 32'h8);
    check("lb dm_addr", obs_addr0, 32'h100);
    check("lb stall cycles", obs_stall, 4);
    check("lb result", obs_done_wdata, 32'hFFFFFF80);
    txn(SH, 32'h202, 32'hABCD1234, 32'h0, 5'd5, 1'b1, 2, 0, 0, 1'b0, 32'h0);
    check("sh dm_we", 32'(obs_we0), 32'd1);
    check("sh dm_sel", 32'(obs_sel0), 32'hC);
    check("sh dm_wdata", obs_dwd0, 32'h12341234);
    check("sh wb_wreg", 32'(obs_done_wreg), 32'd0);
    txn(LW, 32'h101, 32'h0, 32'h0, 5'd6, 1'b1, 0, 0, 0, 1'b0, 32'h0);
    check("lw mis addr_err", 32'(obs_aerr0), 32'd1);
    check("lw mis dm_req", 32'(obs_req0), 32'd0);
    check("lw mis wb_wreg", 32'(obs_wreg0), 32'd0);
    txn(LW, 32'h300, 32'h0, 32'h0, 5'd7, 1'b1, 1000, 1, 0, 1'b0, 32'h0);
    check("timeout bus_err pulses", obs_berr, 1);
    check("timeout stall cycles", obs_stall, TMO + 1);
    check("timeout wb_wreg", 32'(obs_done_wreg), 32'd0);
    txn(LW, 32'h304, 32'h0, 32'h0, 5'd8, 1'b1, TMO, 0, 0, 1'b1, 32'hCAFEF00D);
    check("coincide bus_err pulses", obs_berr, 0);
    check("coincide result", obs_done_wdata, 32'hCAFEF00D);
    txn(LW, 32'h500, 32'h0, 32'h0, 5'd9, 1'b1, 1000, 0, 5, 1'b0, 32'h0);
    chk_on = 1'b0; rst = 1'b1; bus.mem_aluop = ADD; bus.dm_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    txn(ADD, 32'h0, 32'h0, 32'h55AA, 5'd10, 1'b1, 0, 0, 0, 1'b0, 32'h0);
    check("post-reset dm_req", 32'(obs_req0), 32'd0);
    check("post-reset wb_wdata", obs_wdata0, 32'h55AA);
    txn(LHU, 32'h42, 32'h0, 32'h0, 5'd11, 1'b1, 2, 2, 0, 1'b1, 32'h9ABC1234);
    check("lhu done cycles", obs_done, 3);
    check("lhu held stable", obs_chg, 0);
    check("lhu result", obs_done_wdata, 32'h00009ABC);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      ack = r < 2 ? TMO : r < 3 ? 1000 : $urandom_range(1, 6);
      txn(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
          ack, $urandom_range(0, 3), 0, 1'b0, 32'h0);
    end
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
